// File: rtl/auth_cmd_tx_pkg.sv
// auth_cmd_tx_pkg: shared FSM state type and command byte constants
package auth_cmd_tx_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   localparam logic [7:0] CMD_GO   = 8'h47;
   localparam logic [7:0] CMD_STOP = 8'h53;
endpackage

// File: rtl/auth_cmd_tx_uart_tx.sv
// uart_tx: 8N1 serializer with bit-period counter, bit index and shift register
module uart_tx
   import auth_cmd_tx_pkg::*;
#(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       TX,
   output logic       tx_done
);
   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic [2:0] idx;
   logic [7:0] shreg;
   logic bit_end, tx_nxt;
   assign bit_end = cnt == LAST;
   // state register, registered line output and datapath counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         TX    <= 1'b1;
      end else begin
         state <= nxt;
         TX    <= tx_nxt;
         cnt   <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
         if (state == IDLE && trmt) shreg <= tx_data;
         else if (state == DATA && bit_end) shreg <= shreg >> 1;
         if (state == DATA && bit_end) idx <= idx + 1'b1;
      end
   end
   // next-state: each non-idle state lasts whole bit periods
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (trmt) nxt = START;
         START:   if (bit_end) nxt = DATA;
         DATA:    if (bit_end && idx == 3'd7) nxt = STOP;
         STOP:    if (bit_end) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // line value for the next cycle; done marks the last stop-bit cycle
   always_comb begin
      tx_nxt  = 1'b1;
      tx_done = 1'b0;
      case (state)
         IDLE:    tx_nxt = ~trmt;
         START:   tx_nxt = bit_end ? shreg[0] : 1'b0;
         DATA:    tx_nxt = bit_end ? ((idx == 3'd7) ? 1'b1 : shreg[1]) : TX;
         STOP:    tx_done = bit_end;
         default: tx_nxt = 1'b1;
      endcase
   end
endmodule

// File: rtl/auth_cmd_tx.sv
// auth_cmd_tx: latches go/stop command requests and sends them over the UART
module auth_cmd_tx
   import auth_cmd_tx_pkg::*;
#(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go_req,
   input  logic       stop_req,
   output logic       TX,
   output logic       tx_busy,
   output logic       cmd_done,
   output logic [7:0] sent_cmd
);
   logic pend_g, pend_s, trmt, running, tx_done;
   logic [7:0] cur, tx_data;
   assign tx_data = pend_s ? CMD_STOP : CMD_GO;
   assign tx_busy = running | pend_g | pend_s;
   // pending flags, launch strobe (stop wins) and completion reporting
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_g   <= 1'b0;
         pend_s   <= 1'b0;
         trmt     <= 1'b0;
         running  <= 1'b0;
         cur      <= '0;
         cmd_done <= 1'b0;
         sent_cmd <= '0;
      end else begin
         pend_s   <= (pend_s & ~trmt) | stop_req;
         pend_g   <= (pend_g & ~(trmt & ~pend_s)) | go_req;
         trmt     <= ~trmt & (pend_g | pend_s) & (~running | tx_done);
         running  <= trmt | (running & ~tx_done);
         cmd_done <= tx_done;
         if (trmt) cur <= tx_data;
         if (tx_done) sent_cmd <= cur;
      end
   end
   uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
      .clk    (clk),
      .rst    (rst),
      .trmt   (trmt),
      .tx_data(tx_data),
      .TX     (TX),
      .tx_done(tx_done)
   );
endmodule

// File: doc/auth_cmd_tx.md
AUTH_CMD_TX -- requirements
Module: auth_cmd_tx

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 2604, giving clock cycles per UART bit (19200 baud at 50 MHz).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port go_req, input, 1, a one-cycle request to send the power-up command 'G' (8'h47).
REQ-005 The block SHALL have port stop_req, input, 1, a one-cycle request to send the stop command 'S' (8'h53).
REQ-006 The block SHALL have port TX, output, 1, the UART serial line, idle high.
REQ-007 The block SHALL have port tx_busy, output, 1, high while a frame is on the line or any command is pending.
REQ-008 The block SHALL have port cmd_done, output, 1, a one-cycle pulse at the end of each stop bit.
REQ-009 The block SHALL have port sent_cmd, output, 8, the last byte fully transmitted, valid from the cmd_done pulse onward.

Function
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly BAUD_DIV cycles; 10*BAUD_DIV cycles per frame.
REQ-011 Each request SHALL set its pending flag (pend_g / pend_s) at the sampling edge; a request for an already-pending command merges into it.
REQ-012 Controller FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE: if a flag is pending, load the byte, clear that flag, drive TX=0, go to START.
- START -> DATA after BAUD_DIV cycles.
- DATA -> STOP after 8 bit periods.
- STOP -> IDLE after BAUD_DIV cycles, pulsing cmd_done.
REQ-013 The start bit SHALL begin (TX low) at the second rising edge after the edge that samples a request made in IDLE with nothing pending.
REQ-014 When both flags are pending in IDLE, 'S' SHALL be sent first and 'G' in the following frame.
REQ-015 A request arriving during a frame SHALL be latched and start its frame from IDLE exactly one cycle after cmd_done; this applies even when it matches the byte in flight.
REQ-016 go_req and stop_req asserted in the same cycle SHALL both be latched.
REQ-017 The bit-period counter SHALL be wide enough for BAUD_DIV-1, SHALL count 0..BAUD_DIV-1, and SHALL wrap to 0 at each bit boundary.
REQ-018 The data bit index SHALL be a 3-bit counter; DATA exits when the index is 7 and the bit period expires.
REQ-019 TX SHALL be a registered output with no combinational path from go_req or stop_req.
REQ-020 tx_busy SHALL be high in any cycle where the FSM is not IDLE or either pending flag is set.

Reset
REQ-021 On rst, the following SHALL hold at the next edge:
- TX=1, tx_busy=0, cmd_done=0, sent_cmd=8'h00
- FSM=IDLE, counters=0, both pending flags cleared
REQ-022 A reset mid-frame SHALL abort the frame; TX goes high at the next edge and no cmd_done is issued.
REQ-023 A request asserted in the same cycle as rst SHALL be discarded.

Structure
REQ-024 A shared package SHALL hold the FSM state enum, CMD_GO=8'h47 and CMD_STOP=8'h53; the receive-side authorization logic uses the same constants.
REQ-025 The serializer (shift register, bit-period counter, bit index) SHALL be the sub-module uart_tx, with ports:
- inputs: clk, rst, trmt, tx_data[7:0]
- outputs: TX, tx_done
REQ-026 The command arbitration and pending flags SHALL live in auth_cmd_tx.

Verification (BAUD_DIV=8 in bench)
REQ-027 go_req pulse at cycle 10 -> TX low from cycle 12, observes 0,1,1,1,0,0,0,1,0,1 each for 8 cycles, cmd_done at frame end, sent_cmd=8'h47.
REQ-028 go_req and stop_req in the same cycle -> frame 8'h53 then frame 8'h47, second start bit one cycle after first cmd_done, two cmd_done pulses.
REQ-029 go_req pulsed three times during an 'S' frame -> exactly one 'G' frame follows; tx_busy stays high throughout.
REQ-030 rst asserted during data bit 4 -> TX=1 next edge, no cmd_done, tx_busy=0, no frame resumes.
REQ-031 stop_req during a 'S' frame -> a second 'S' frame follows; idle bench -> TX constantly 1, tx_busy=0.
